// File: rtl/buffer_readout_if.sv
// Purpose: RAM read port and tx source port between buffer_readout and its neighbours.
// Signals:
//   ram_rd_addr, ram_rd_en : read request towards the sample RAM
//   ram_rd_data            : RAM word, valid one cycle after ram_rd_en
//   tx_data, tx_rdy, tx_eof: word offered to the tx protocol mux
//   tx_ack                 : tx protocol consumed the offered word
// Modports: master = readout engine, slave = RAM plus tx mux side.
interface buffer_readout_if #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned RAM_DATA_WIDTH = 8,
    parameter int unsigned TX_DATA_WIDTH  = 8
);

    logic [ADDR_WIDTH-1:0]     ram_rd_addr;
    logic                      ram_rd_en;
    logic [RAM_DATA_WIDTH-1:0] ram_rd_data;
    logic [TX_DATA_WIDTH-1:0]  tx_data;
    logic                      tx_rdy;
    logic                      tx_eof;
    logic                      tx_ack;

    modport master (
        output ram_rd_addr,
        output ram_rd_en,
        input  ram_rd_data,
        output tx_data,
        output tx_rdy,
        output tx_eof,
        input  tx_ack
    );

    modport slave (
        input  ram_rd_addr,
        input  ram_rd_en,
        output ram_rd_data,
        input  tx_data,
        input  tx_rdy,
        input  tx_eof,
        output tx_ack
    );

endinterface

// File: rtl/buffer_readout.sv
// Purpose: streams the newest num_samples words of a circular sample RAM to the
// tx protocol mux, oldest first, one RAM read per word, eof on the final word.
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   rqst_data    : single-cycle host request to send the buffer
//   wr_addr_last : address of the most recently written sample
//   num_samples  : number of words to send (clamped to RAM_SIZE)
//   bus          : RAM read port and tx source port (master side)
//   busy         : a transfer is in progress
module buffer_readout #(
    parameter int unsigned RAM_DATA_WIDTH = 8,
    parameter int unsigned TX_DATA_WIDTH  = 8,
    parameter int unsigned RAM_SIZE       = 4096,
    parameter int unsigned ADDR_WIDTH     = $clog2(RAM_SIZE),
    parameter int unsigned REG_DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rqst_data,
    input  logic [ADDR_WIDTH-1:0]     wr_addr_last,
    input  logic [REG_DATA_WIDTH-1:0] num_samples,
    buffer_readout_if.master          bus,
    output logic                      busy
);

    // One extra bit so RAM_SIZE itself is representable after clamping.
    localparam int unsigned CNT_WIDTH = REG_DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] RAM_SIZE_CNT = CNT_WIDTH'(RAM_SIZE);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_READ    = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_PRESENT = 2'd3;

    logic [1:0]               state_q,     state_d;
    logic [ADDR_WIDTH-1:0]    addr_q,      addr_d;
    logic [CNT_WIDTH-1:0]     cnt_q,       cnt_d;
    logic [TX_DATA_WIDTH-1:0] tx_data_q,   tx_data_d;
    logic                     tx_rdy_q,    tx_rdy_d;
    logic                     tx_eof_q,    tx_eof_d;
    logic                     ram_rd_en_q, ram_rd_en_d;
    logic                     busy_q,      busy_d;

    logic [CNT_WIDTH-1:0]      req_cnt_c;
    logic [RAM_DATA_WIDTH-1:0] rd_word_c;

    assign rd_word_c = bus.ram_rd_data;

    // Requested length clamped to the RAM depth.
    always_comb begin
        req_cnt_c = CNT_WIDTH'(num_samples);
        if (CNT_WIDTH'(num_samples) > RAM_SIZE_CNT) begin
            req_cnt_c = RAM_SIZE_CNT;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        tx_rdy_d    = tx_rdy_q;
        tx_eof_d    = tx_eof_q;
        ram_rd_en_d = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (rqst_data && (num_samples != '0)) begin
                    cnt_d       = req_cnt_c;
                    // Oldest sample sits cnt-1 words behind the last write; wraps naturally.
                    addr_d      = wr_addr_last - ADDR_WIDTH'(req_cnt_c) + ADDR_WIDTH'(1);
                    ram_rd_en_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tx_data_d = TX_DATA_WIDTH'(rd_word_c);
                tx_eof_d  = (cnt_q == CNT_ONE);
                tx_rdy_d  = 1'b1;
                state_d   = S_PRESENT;
            end
            S_PRESENT: begin
                if (bus.tx_ack) begin
                    tx_rdy_d = 1'b0;
                    tx_eof_d = 1'b0;
                    if (cnt_q == CNT_ONE) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        addr_d      = addr_q + ADDR_WIDTH'(1);
                        cnt_d       = cnt_q - CNT_ONE;
                        ram_rd_en_d = 1'b1;
                        state_d     = S_READ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            tx_data_q   <= '0;
            tx_rdy_q    <= 1'b0;
            tx_eof_q    <= 1'b0;
            ram_rd_en_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            tx_rdy_q    <= tx_rdy_d;
            tx_eof_q    <= tx_eof_d;
            ram_rd_en_q <= ram_rd_en_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ram_rd_addr = addr_q;
    assign bus.ram_rd_en   = ram_rd_en_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_rdy      = tx_rdy_q;
    assign bus.tx_eof      = tx_eof_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_buffer_readout.sv
// Bench for buffer_readout with a 16-word RAM whose contents equal the address.
module tb_buffer_readout;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rqst_data = 1'b0;
    logic [3:0]  wr_addr_last = 4'd0;
    logic [15:0] num_samples = 16'd0;
    logic        busy;

    buffer_readout_if #(.ADDR_WIDTH(4), .RAM_DATA_WIDTH(8), .TX_DATA_WIDTH(8)) bus ();

    buffer_readout #(
        .RAM_DATA_WIDTH(8),
        .TX_DATA_WIDTH (8),
        .RAM_SIZE      (16),
        .REG_DATA_WIDTH(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rqst_data   (rqst_data),
        .wr_addr_last(wr_addr_last),
        .num_samples (num_samples),
        .bus         (bus),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // RAM model: data equals address, one cycle read latency.
    initial bus.ram_rd_data = 8'd0;
    always @(posedge clk) begin
        if (bus.ram_rd_en) bus.ram_rd_data <= 8'(bus.ram_rd_addr);
    end

    // Ack driver: acks each offered word after hold_left waiting cycles;
    // stray_mode additionally raises tx_ack while busy but nothing is offered.
    bit auto_ack = 1'b1;
    int hold_left = 0;
    bit stray_mode = 1'b0;
    initial bus.tx_ack = 1'b0;
    always @(posedge clk) begin
        #2;
        if (bus.tx_rdy && auto_ack) begin
            if (hold_left > 0) begin
                bus.tx_ack = 1'b0;
                hold_left--;
            end else begin
                bus.tx_ack = 1'b1;
            end
        end else begin
            bus.tx_ack = stray_mode && busy;
        end
    end

    // Behavioural model: a queue of words still owed, plus the edge of the last
    // start/ack event; each word is offered from two edges after that event on.
    int edge_n = 0;
    bit m_active = 1'b0;
    int m_ev = 0;
    int m_q[$];

    always @(posedge clk) begin
        bit rdy_before;
        int cnt;
        int start;
        rdy_before = m_active && (edge_n >= m_ev + 2);
        edge_n++;
        if (!rst) begin
            m_active = 1'b0;
            m_q.delete();
        end else if (!m_active) begin
            if (rqst_data && (num_samples != 16'd0)) begin
                cnt   = (int'(num_samples) > 16) ? 16 : int'(num_samples);
                start = ((int'(wr_addr_last) - cnt + 1) % 16 + 16) % 16;
                for (int i = 0; i < cnt; i++) m_q.push_back((start + i) % 16);
                m_active = 1'b1;
                m_ev     = edge_n;
            end
        end else if (rdy_before && bus.tx_ack) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_active = 1'b0;
            else m_ev = edge_n;
        end
    end

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        bit exp_rdy;
        if (!rst) begin
            chk("rst_ram_rd_addr", int'(bus.ram_rd_addr), 0);
            chk("rst_ram_rd_en", int'(bus.ram_rd_en), 0);
            chk("rst_tx_data", int'(bus.tx_data), 0);
            chk("rst_tx_rdy", int'(bus.tx_rdy), 0);
            chk("rst_tx_eof", int'(bus.tx_eof), 0);
            chk("rst_busy", int'(busy), 0);
        end else begin
            exp_rdy = m_active && (edge_n >= m_ev + 2);
            chk("busy", int'(busy), int'(m_active));
            chk("ram_rd_en", int'(bus.ram_rd_en), int'(m_active && (edge_n == m_ev)));
            chk("tx_rdy", int'(bus.tx_rdy), int'(exp_rdy));
            if (m_active) chk("ram_rd_addr", int'(bus.ram_rd_addr), m_q[0]);
            if (exp_rdy && bus.tx_rdy) begin
                chk("tx_data", int'(bus.tx_data), m_q[0]);
                chk("tx_eof", int'(bus.tx_eof), int'(m_q.size() == 1));
            end
        end
    end

    // Log of accepted words, for literal frame checks.
    int log_data[$];
    int log_eof[$];
    int rdy_cycles = 0;
    always @(negedge clk) begin
        if (rst && bus.tx_rdy) begin
            rdy_cycles++;
            if (bus.tx_ack) begin
                log_data.push_back(int'(bus.tx_data));
                log_eof.push_back(int'(bus.tx_eof));
            end
        end
    end

    int exp_q[$];

    task automatic check_log(input string name);
        chk({name, "_len"}, log_data.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_data.size(); i++) begin
            chk($sformatf("%s_word%0d", name, i), log_data[i], exp_q[i]);
            chk($sformatf("%s_eof%0d", name, i), log_eof[i], (i == exp_q.size() - 1) ? 1 : 0);
        end
        log_data.delete();
        log_eof.delete();
    endtask

    task automatic drive_rqst(input int wla, input int ns);
        @(posedge clk); #2;
        wr_addr_last = 4'(wla);
        num_samples  = 16'(ns);
        rqst_data    = 1'b1;
        @(posedge clk); #2;
        rqst_data = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout: busy still 1 after 300 cycles, required 0", name);
    endtask

    initial begin
        int n;
        int act;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Basic frame with start-latency measurement.
        @(posedge clk); #2;
        wr_addr_last = 4'd9;
        num_samples  = 16'd4;
        rqst_data    = 1'b1;
        @(posedge clk); #2;
        rqst_data = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (bus.tx_rdy) break;
        end
        chk("basic_first_rdy_cycle", n, 3);
        wait_idle("basic");
        exp_q = '{6, 7, 8, 9};
        check_log("basic");

        // Wrap-around.
        drive_rqst(1, 4);
        wait_idle("wrap");
        exp_q = '{14, 15, 0, 1};
        check_log("wrap");

        // Clamp to RAM depth.
        drive_rqst(1, 20);
        wait_idle("clamp");
        exp_q = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1};
        check_log("clamp");

        // Zero length produces no activity.
        drive_rqst(7, 0);
        act = 0;
        repeat (20) begin
            @(negedge clk);
            act += int'(bus.tx_rdy) + int'(bus.ram_rd_en) + int'(busy);
        end
        chk("zero_len_activity", act, 0);
        exp_q.delete();
        check_log("zero_len");

        // Backpressure, ignored request during hold, stray acks.
        hold_left  = 5;
        stray_mode = 1'b1;
        rdy_cycles = 0;
        drive_rqst(5, 3);
        repeat (3) @(posedge clk);
        #2;
        num_samples = 16'd1;
        rqst_data   = 1'b1;
        @(posedge clk); #2;
        rqst_data = 1'b0;
        wait_idle("bp");
        stray_mode = 1'b0;
        chk("bp_rdy_cycles", rdy_cycles, 8);
        exp_q = '{3, 4, 5};
        check_log("bp");

        // Reset during the second word of an 8-word frame.
        drive_rqst(9, 8);
        n = 0;
        while (n < 100 && !(log_data.size() == 1 && bus.ram_rd_en)) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_second_word", int'(log_data.size() == 1 && bus.ram_rd_en), 1);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_low_busy", int'(busy), 0);
        chk("rst_low_rdy", int'(bus.tx_rdy), 0);
        @(posedge clk); #2;
        rst = 1'b1;
        log_data.delete();
        log_eof.delete();
        repeat (5) @(negedge clk);
        chk("post_rst_idle_busy", int'(busy), 0);
        drive_rqst(9, 2);
        wait_idle("post_rst");
        exp_q = '{8, 9};
        check_log("post_rst");

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
